// File: rtl/h2_axi_mem_pkg.sv
// Shared types and helpers for the H2 AXI memory responder.
//   w_state_e  : write engine states
//   r_state_e  : read engine states
//   BEAT_BYTES : bytes per beat at the default 512-bit data width
//   word_index : byte address -> memory word index (low beat bits dropped,
//                bits above the index width ignored)
package h2_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_BURST = 2'd1,
    R_DRAIN = 2'd2
  } r_state_e;

  localparam int BEAT_BYTES = 64;

  function automatic logic [31:0] word_index(input logic [63:0] addr,
                                             input int          lsb,
                                             input int          aw);
    logic [63:0] mask;
    mask = (64'd1 << aw) - 64'd1;
    return 32'((addr >> lsb) & mask);
  endfunction

endpackage

// File: rtl/h2_axi_mem_rfifo.sv
// Two-entry FIFO used as the read skid buffer. Each entry holds one read beat
// {rlast, rdata}; the entry is loaded straight from the memory array, so the
// entry register doubles as the registered RAM output.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : load push_data (caller guarantees a free slot)
//   pop        : drop the head entry (caller guarantees count != 0)
//   pop_data   : head entry, stable until popped
//   count      : occupied entries, 0..2
module h2_axi_mem_rfifo #(
  parameter int W = 513
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] data_q [2];
  logic [W-1:0] data_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  // Storage is reset too so that rdata reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      data_q    <= data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pop_data = data_q[rd_ptr_q];
  assign count    = cnt_q;

endmodule

// File: rtl/h2_axi_mem_responder.sv
// AXI4 slave memory responder for the H2 accelerator DDR port. Accepts INCR
// bursts of full-width beats (no IDs, no RESP) against an internal
// word-addressed memory. Independent write and read engines.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*      : write address / data / response channels
//   axi_ar*/axi_r*             : read address / data channels
//   err_wlast                  : sticky, wlast disagreed with the beat count
//   err_unaligned              : sticky, awaddr/araddr had nonzero beat bits
module h2_axi_mem_responder
  import h2_axi_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 8 * BEAT_BYTES,
  parameter int MEM_DEPTH      = 4096,
  parameter int MEM_AW         = $clog2(MEM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                  axi_awlen,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                        axi_wlast,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                  axi_arlen,
  output logic                        axi_rvalid,
  input  logic                        axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic                        axi_rlast,
  output logic                        err_wlast,
  output logic                        err_unaligned
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int BEAT_LSB = $clog2(STRB_W);

  // Holds both address channels closed for the reset-release cycle.
  logic              alive_q, alive_d;
  w_state_e          w_state_q, w_state_d;
  logic [MEM_AW-1:0] w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  r_state_e          r_state_q, r_state_d;
  logic [MEM_AW-1:0] r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic              err_wlast_q, err_wlast_d;
  logic              err_unal_q, err_unal_d;

  logic                    mem_we;
  logic [AXI_DATA_WIDTH-1:0] mem_ram [MEM_DEPTH];

  logic                    fifo_push, fifo_push_last, fifo_pop;
  logic [AXI_DATA_WIDTH:0] fifo_push_data, fifo_pop_data;
  logic [1:0]              fifo_cnt;

  logic w_final, aw_unal, ar_unal;

  assign w_final = (w_cnt_q == w_len_q);
  assign aw_unal = |axi_awaddr[BEAT_LSB-1:0];
  assign ar_unal = |axi_araddr[BEAT_LSB-1:0];

  // Write engine: address, beat-counted data, response.
  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    err_wlast_d = err_wlast_q;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    mem_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        axi_awready = alive_q;
        if (axi_awvalid && alive_q) begin
          w_idx_d   = MEM_AW'(word_index(64'(axi_awaddr), BEAT_LSB, MEM_AW));
          w_len_d   = axi_awlen;
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          mem_we = 1'b1;
          // The beat count ends the burst; wlast is only audited.
          if (axi_wlast != w_final) err_wlast_d = 1'b1;
          if (w_final) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            w_idx_d = w_idx_q + MEM_AW'(1);
          end
        end
      end
      W_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign fifo_pop = axi_rvalid && axi_rready;

  // Read engine: one memory read per cycle while the FIFO can take it.
  // A pop in the same cycle frees a slot, so a full FIFO still streams.
  always_comb begin
    r_state_d      = r_state_q;
    r_idx_d        = r_idx_q;
    r_len_d        = r_len_q;
    r_cnt_d        = r_cnt_q;
    axi_arready    = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_last = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        axi_arready = alive_q;
        if (axi_arvalid && alive_q) begin
          r_idx_d   = MEM_AW'(word_index(64'(axi_araddr), BEAT_LSB, MEM_AW));
          r_len_d   = axi_arlen;
          r_cnt_d   = 8'd0;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (fifo_cnt != 2'd2 || fifo_pop) begin
          fifo_push      = 1'b1;
          fifo_push_last = (r_cnt_q == r_len_q);
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_DRAIN;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            r_idx_d = r_idx_q + MEM_AW'(1);
          end
        end
      end
      R_DRAIN: begin
        // Leave as the last beat is taken so AR reopens on the next cycle.
        if (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && fifo_pop)) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    alive_d    = 1'b1;
    err_unal_d = err_unal_q
               | (axi_awvalid && axi_awready && aw_unal)
               | (axi_arvalid && axi_arready && ar_unal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q     <= 1'b0;
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_len_q     <= 8'd0;
      w_cnt_q     <= 8'd0;
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      r_len_q     <= 8'd0;
      r_cnt_q     <= 8'd0;
      err_wlast_q <= 1'b0;
      err_unal_q  <= 1'b0;
    end else begin
      alive_q     <= alive_d;
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      err_wlast_q <= err_wlast_d;
      err_unal_q  <= err_unal_d;
    end
  end

  // Memory is not reset. The FIFO samples the old word on a same-edge
  // write to the same index, giving read-first behaviour.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (mem_we && axi_wstrb[b]) mem_ram[w_idx_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
    end
  end

  assign fifo_push_data = {fifo_push_last, mem_ram[r_idx_q]};

  h2_axi_mem_rfifo #(
    .W (AXI_DATA_WIDTH + 1)
  ) u_rfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_cnt)
  );

  assign axi_rvalid    = (fifo_cnt != 2'd0);
  assign axi_rdata     = fifo_pop_data[AXI_DATA_WIDTH-1:0];
  assign axi_rlast     = fifo_pop_data[AXI_DATA_WIDTH];
  assign err_wlast     = err_wlast_q;
  assign err_unaligned = err_unal_q;

endmodule

// File: tb/tb_h2_axi_mem_responder.sv
// Bench for h2_axi_mem_responder: directed bursts plus randomized traffic,
// checked against a word-array memory model and a read-beat scoreboard.
module tb_h2_axi_mem_responder;

  localparam int DW    = 512;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [63:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          err_wlast, err_unaligned;

  always #5 clk = ~clk;

  h2_axi_mem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axi_awvalid   (awvalid),
    .axi_awready   (awready),
    .axi_awaddr    (awaddr),
    .axi_awlen     (awlen),
    .axi_wvalid    (wvalid),
    .axi_wready    (wready),
    .axi_wdata     (wdata),
    .axi_wstrb     (wstrb),
    .axi_wlast     (wlast),
    .axi_bvalid    (bvalid),
    .axi_bready    (bready),
    .axi_arvalid   (arvalid),
    .axi_arready   (arready),
    .axi_araddr    (araddr),
    .axi_arlen     (arlen),
    .axi_rvalid    (rvalid),
    .axi_rready    (rready),
    .axi_rdata     (rdata),
    .axi_rlast     (rlast),
    .err_wlast     (err_wlast),
    .err_unaligned (err_unaligned)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            rr_mode = 0;   // 0: rready high, 1: random, 2: low

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [DW-1:0] rword();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Wait for ready on channel ch (0 AW, 1 W, 2 AR); returns #1 after the
  // handshake edge, n = cycles spent waiting.
  task automatic wait_rdy(input int ch, output int n);
    logic r;
    n = 0;
    forever begin
      @(negedge clk);
      r = (ch == 0) ? awready : (ch == 1) ? wready : arready;
      if (r) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL hs_timeout ch=%0d: ready low for %0d cycles, required high", ch, n);
        finish_tb();
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [63:0] addr, input int len, input int bad_last,
                           input bit gaps);
    int idx, n, hold;
    idx = int'((addr >> 6) & 64'(DEPTH - 1));
    @(posedge clk);
    #1;
    awaddr  = addr;
    awlen   = 8'(len);
    awvalid = 1'b1;
    wait_rdy(0, n);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps && b > 0) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wdata  = wd[b];
      wstrb  = ws[b];
      wlast  = (bad_last >= 0) ? (b == bad_last) : (b == len);
      wvalid = 1'b1;
      wait_rdy(1, n);
      if (b == 0) chk("wready_lat", n, 0);
      if (b < len) chk("bvalid_early", bvalid, 0);
      for (int k = 0; k < SW; k++)
        if (ws[b][k]) model[(idx + b) % DEPTH][k*8 +: 8] = wd[b][k*8 +: 8];
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    @(negedge clk);
    chk("bvalid_lat", bvalid, 1);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    chk("aw_after_b", {bvalid, awready}, 2'b01);
  endtask

  task automatic axi_read(input logic [63:0] addr, input int len, input int mode);
    int idx, n, t0, t1;
    beat_t e;
    idx     = int'((addr >> 6) & 64'(DEPTH - 1));
    rr_mode = mode;
    @(posedge clk);
    #1;
    for (int b = 0; b <= len; b++) begin
      e.data = model[(idx + b) % DEPTH];
      e.last = (b == len);
      exp_q.push_back(e);
    end
    araddr  = addr;
    arlen   = 8'(len);
    arvalid = 1'b1;
    wait_rdy(2, n);
    arvalid = 1'b0;
    t0 = cyc;
    @(negedge clk);
    chk("rvalid_early", rvalid, 0);
    @(negedge clk);
    chk("rvalid_lat", rvalid, 1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 2000);
    #1;
    t1 = cyc;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL r_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    if (mode == 0) chk("r_thru", t1 - t0, len + 2);
    @(negedge clk);
    chk("ar_after_r", {rvalid, arready}, 2'b01);
  endtask

  // rready driver
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Read monitor: pops the scoreboard on each handshake, checks stall stability.
  initial begin
    beat_t         e;
    logic          hold_v;
    logic [DW:0]   hold_b;
    hold_v = 1'b0;
    hold_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("r_stall_stable", {rvalid, rlast, rdata}, {1'b1, hold_b});
        hold_v = rvalid && !rready;
        hold_b = {rlast, rdata};
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_unexpected: got beat %h, required none", {rlast, rdata});
          end else begin
            e = exp_q.pop_front();
            chk("rbeat", {rlast, rdata}, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    finish_tb();
  end

  initial begin
    int            n, a, l, k;
    logic [DW-1:0] v;
    awvalid = 1'b0; awaddr = '0; awlen = '0;
    wvalid  = 1'b0; wdata  = '0; wstrb = '0; wlast = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0; araddr = '0; arlen = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", {err_wlast, err_unaligned}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("rel_aw_low", {awready, arready}, 2'b00);
    @(negedge clk);
    chk("rel_aw_high", {awready, arready}, 2'b11);

    // Basic 4-beat write/read at 0x40
    for (int b = 0; b < 4; b++) begin wd[b] = DW'(b); ws[b] = '1; end
    axi_write(64'h40, 3, -1, 1'b0);
    axi_read(64'h40, 3, 0);

    // Fill words 0..255 with random data
    for (int b = 0; b < 256; b++) begin wd[b] = rword(); ws[b] = '1; end
    axi_write(64'h0, 255, -1, 1'b1);

    // Partial strobe over an all-ones word
    wd[0] = '1; ws[0] = '1;
    axi_write(64'd10 * 64, 0, -1, 1'b0);
    wd[0] = '0; ws[0] = 64'hF;
    axi_write(64'd10 * 64, 0, -1, 1'b0);
    axi_read(64'd10 * 64, 0, 0);

    // 16-beat read under random backpressure
    axi_read(64'd100 * 64, 15, 1);

    // Wrap across the end of memory
    for (int b = 0; b < 4; b++) begin wd[b] = rword(); ws[b] = '1; end
    axi_write(64'(DEPTH - 2) * 64, 3, -1, 1'b1);
    axi_read(64'(DEPTH - 2) * 64, 3, 1);
    chk("err_clean", {err_wlast, err_unaligned}, 2'b00);

    // Early wlast
    for (int b = 0; b < 4; b++) begin wd[b] = rword(); ws[b] = '1; end
    axi_write(64'd50 * 64, 3, 1, 1'b0);
    chk("err_wlast_set", {err_wlast, err_unaligned}, 2'b10);

    // Unaligned and high-bit addresses
    axi_read(64'h40 + 64'd5, 1, 0);
    chk("err_unal_set", err_unaligned, 1);
    axi_read((64'h1234 << 40) | (64'd60 * 64), 2, 1);

    // Same-word read and write on the same edge: read-first
    k = 20;
    v = rword();
    @(posedge clk);
    #1;
    exp_q.push_back('{last: 1'b1, data: model[k]});
    awaddr = 64'(k) * 64; awlen = 8'd0; awvalid = 1'b1;
    araddr = 64'(k) * 64; arlen = 8'd0; arvalid = 1'b1;
    wdata = v; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("cc_ready", {awready, arready}, 2'b11);
    @(posedge clk);
    #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("cc_wready", wready, 1);
    @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0;
    model[k] = v;
    @(negedge clk);
    chk("cc_bvalid", bvalid, 1);
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    chk("cc_drained", exp_q.size(), 0);
    axi_read(64'(k) * 64, 0, 0);

    // Randomized traffic over words 0..255
    for (int it = 0; it < 24; it++) begin
      a = $urandom_range(0, 240);
      l = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= l; b++) begin wd[b] = rword(); ws[b] = {$urandom, $urandom}; end
        axi_write(64'(a) * 64, l, -1, 1'b1);
      end else begin
        axi_read(64'(a) * 64, l, 1);
      end
    end

    // Reset in the middle of a write and a stalled read
    @(posedge clk);
    #1;
    awaddr = 64'd30 * 64; awlen = 8'd3; awvalid = 1'b1;
    wait_rdy(0, n);
    awvalid = 1'b0;
    v = rword();
    wdata = v; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
    wait_rdy(1, n);
    wvalid = 1'b0;
    model[30] = v;
    rr_mode = 2;
    araddr = 64'h0; arlen = 8'd3; arvalid = 1'b1;
    wait_rdy(2, n);
    arvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rvalid", {rvalid, wready}, 2'b11);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_ready", {awready, wready, arready}, 3'b000);
    chk("mid_rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", {err_wlast, err_unaligned}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rr_mode = 0;
    @(negedge clk);
    chk("post_rst_ready", {awready, arready}, 2'b11);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {bvalid, rvalid}, 2'b00);
    end
    axi_read(64'd28 * 64, 3, 0);

    finish_tb();
  end

endmodule

// File: doc/h2_axi_mem_responder.md
# h2_axi_mem_responder

AXI4 slave-side memory responder that answers the DDR master port of the H2 accelerator top: it accepts AR/AW bursts, returns R beats, absorbs W beats, and issues B responses against an internal word-addressed memory. It is used in block- and system-level simulation, and in emulation builds where real DDR is replaced by on-chip RAM. It implements exactly the channel subset the accelerator drives: no IDs, no RESP fields, INCR bursts of full-width beats.

## Interface
- AXI_ADDR_WIDTH, 64, byte address width
- AXI_DATA_WIDTH, 512, beat width; strobe width AXI_DATA_WIDTH/8
- MEM_DEPTH, 4096, memory depth in beats (power of two)
- MEM_AW, $clog2(MEM_DEPTH), word index width (derived)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- axi_awvalid / axi_awready  in / out  1  write address handshake
- axi_awaddr  in  AXI_ADDR_WIDTH  burst start byte address
- axi_awlen  in  8  beats minus one
- axi_wvalid / axi_wready  in / out  1  write data handshake
- axi_wdata  in  AXI_DATA_WIDTH  beat data
- axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables
- axi_wlast  in  1  last beat marker (checked, not trusted)
- axi_bvalid / axi_bready  out / in  1  write response handshake
- axi_arvalid / axi_arready  in / out  1  read address handshake
- axi_araddr  in  AXI_ADDR_WIDTH  burst start byte address
- axi_arlen  in  8  beats minus one
- axi_rvalid / axi_rready  out / in  1  read data handshake
- axi_rdata  out  AXI_DATA_WIDTH  beat data
- axi_rlast  out  1  last read beat
- err_wlast  out  1  sticky: wlast disagreed with beat count
- err_unaligned  out  1  sticky: awaddr/araddr low bits nonzero

## Operation
- Word index = addr[log2(AXI_DATA_WIDTH/8) +: MEM_AW]; higher bits are ignored; index increments per beat modulo MEM_DEPTH (wrap from MEM_DEPTH-1 to 0 inside a burst is legal).
- Unaligned address: low bits truncated, err_unaligned set.
- Write FSM: W_IDLE (awready=1) -> AW handshake latches index, len, clears beat count -> W_DATA (wready=1); each W handshake writes bytes where wstrb=1; beat count==len -> W_RESP (bvalid=1) -> B handshake -> W_IDLE.
- Beat count is authoritative: wlast=1 before the final beat, or wlast=0 on the final beat, sets err_wlast; the burst still ends on count.
- Read FSM: R_IDLE (arready=1) -> AR handshake latches index, len -> R_BURST issues memory reads, feeding a 2-entry output FIFO; issue only when the FIFO has a free slot counting in-flight reads; last beat issued -> R_DRAIN -> FIFO empty -> R_IDLE.
- rlast=1 exactly on beat len of the burst.
- Read and write engines are independent and may run concurrently. Same-word read and write in the same cycle: read returns the old data (read-first).
- Memory contents are not reset; error flags clear only on reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rdata=0, rlast=0, err_*=0; both FSMs in IDLE; awready/arready rise the first cycle after reset release.
- AW handshake at cycle t -> wready=1 at t+1; final W handshake at t -> bvalid=1 at t+1.
- AR handshake at t -> first rvalid at t+2 (1 cycle issue + 1 cycle registered RAM). With rready held high: 1 beat/cycle, burst of N beats ends at t+N+1.
- rready low: rvalid, rdata, and rlast hold stable; no beat is lost or duplicated.
- bvalid holds until bready. The next AW is accepted the cycle after the B handshake. The next AR is accepted the cycle after the last R handshake.
- Reset mid-burst: FSMs abort immediately, the FIFO empties, and no B response is issued.

## Structure
- Package h2_axi_mem_pkg: FSM state enums (w_state_e, r_state_e), beat-byte constant, and word-index function.
- Sub-module h2_axi_mem_rfifo: 2-entry {rdata, rlast} FIFO with count output, used as the read skid buffer. The memory is an inferred simple dual-port RAM with byte-write enable, described inline.

## Test plan
- Write awaddr=0x40, awlen=3, wstrb all ones, data 0..3 -> bvalid 1 cycle after 4th beat. Then read araddr=0x40, arlen=3 -> data 0..3 returned, rlast on beat 3, first rvalid 2 cycles after AR.
- Partial strobe: write wstrb=0x...0F over prior 0xFF..FF word -> readback shows only low 4 bytes changed.
- Random rready toggling on a 16-beat read -> all 16 beats in order, rdata stable while stalled.
- Wrap: awaddr at index MEM_DEPTH-2, awlen=3 -> indices MEM_DEPTH-2, MEM_DEPTH-1, 0, 1 written, verified by readback.
- wlast asserted on beat 1 of a 4-beat burst -> err_wlast=1, bvalid only after beat 4. Reset -> err_wlast=0.
- Concurrent read/write of the same word in the same cycle -> read returns old value, and the next read returns the new value.
